// File: rtl/seven_segment_scan_reader_if.sv
// Frame output channel of the seven-segment scan reader: recovered digits,
// per-digit error flags, valid/ready handshake and the overrun pulse.
interface seven_segment_scan_reader_if #(
    parameter int unsigned DIGITS = 4
) ();
    logic [4*DIGITS-1:0] digits_out;
    logic [DIGITS-1:0]   err_out;
    logic                out_valid;
    logic                out_ready;
    logic                overrun;

    modport master (
        output digits_out,
        output err_out,
        output out_valid,
        output overrun,
        input  out_ready
    );

    modport slave (
        input  digits_out,
        input  err_out,
        input  out_valid,
        input  overrun,
        output out_ready
    );
endinterface

// File: rtl/seven_segment_scan_reader.sv
// Recovers BCD digits from a multiplexed seven-segment bus: debounces each strobe,
// decodes the glyph back to a nibble and presents complete frames over valid/ready.
module seven_segment_scan_reader #(
    parameter int unsigned DIGITS        = 4,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [6:0]                  seg,
    input  logic [DIGITS-1:0]           digit_en,
    seven_segment_scan_reader_if.master frame_o
);

    localparam int unsigned CntW = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef logic [CntW-1:0] cnt_t;
    localparam cnt_t CntMax = cnt_t'(STABLE_CYCLES);
    localparam cnt_t CntCap = cnt_t'(STABLE_CYCLES - 1);

    typedef enum logic {StCollect, StPresent} state_e;

    function automatic logic [4:0] decode(input logic [6:0] s);
        logic [4:0] r;  // {err, nibble}
        case (s)
            7'h7E:   r = 5'h00;
            7'h30:   r = 5'h01;
            7'h6D:   r = 5'h02;
            7'h79:   r = 5'h03;
            7'h33:   r = 5'h04;
            7'h5B:   r = 5'h05;
            7'h5F:   r = 5'h06;
            7'h70:   r = 5'h07;
            7'h7F:   r = 5'h08;
            7'h7B:   r = 5'h09;
            7'h4F:   r = 5'h1E;
            default: r = 5'h1F;
        endcase
        return r;
    endfunction

    logic [6:0]             seg_q, prev_seg_q;
    logic [DIGITS-1:0]      en_q, prev_en_q;
    cnt_t                   cnt_q, cnt_d;
    logic                   one_hot, same, capture;
    logic [IdxW-1:0]        cap_idx;
    logic [4:0]             dec;

    logic [DIGITS-1:0][3:0] slot_q, slot_d;
    logic [DIGITS-1:0]      slot_err_q, slot_err_d;
    logic [DIGITS-1:0]      mask_q, mask_d, mask_w;

    state_e                 state_q, state_d;
    logic [DIGITS-1:0][3:0] digits_q, digits_d;
    logic [DIGITS-1:0]      err_q, err_d;
    logic                   valid_q, valid_d;
    logic                   overrun_q, overrun_d;

    // Debounce: count consecutive identical registered samples with a one-hot strobe.
    always_comb begin
        one_hot = (en_q != '0) && ((en_q & (en_q - 1'b1)) == '0);
        same    = (seg_q == prev_seg_q) && (en_q == prev_en_q);
        if (same && one_hot) begin
            cnt_d = (cnt_q == CntMax) ? CntMax : cnt_q + 1'b1;
        end else begin
            cnt_d = '0;
        end
        capture = (cnt_d == CntCap);
        dec     = decode(seg_q);
    end

    always_comb begin
        cap_idx = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (en_q[i]) cap_idx = IdxW'(i);
        end
    end

    always_comb begin
        slot_d     = slot_q;
        slot_err_d = slot_err_q;
        mask_w     = mask_q;
        if (capture) begin
            slot_d[cap_idx]     = dec[3:0];
            slot_err_d[cap_idx] = dec[4];
            mask_w[cap_idx]     = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        mask_d    = mask_w;
        digits_d  = digits_q;
        err_d     = err_q;
        valid_d   = valid_q;
        overrun_d = 1'b0;
        case (state_q)
            StCollect: begin
                if (mask_q == '1) begin
                    digits_d = slot_d;
                    err_d    = slot_err_d;
                    valid_d  = 1'b1;
                    mask_d   = '0;
                    state_d  = StPresent;
                end
            end
            StPresent: begin
                // Handshake wins over a full mask; the pending frame keeps its mask.
                if (valid_q && frame_o.out_ready) begin
                    valid_d = 1'b0;
                    state_d = StCollect;
                end else if (mask_q == '1) begin
                    overrun_d = 1'b1;
                    mask_d    = '0;
                end
            end
            default: state_d = StCollect;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q      <= '0;
            en_q       <= '0;
            prev_seg_q <= '0;
            prev_en_q  <= '0;
            cnt_q      <= '0;
            slot_q     <= '0;
            slot_err_q <= '0;
            mask_q     <= '0;
            state_q    <= StCollect;
            digits_q   <= '0;
            err_q      <= '0;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            seg_q      <= seg;
            en_q       <= digit_en;
            prev_seg_q <= seg_q;
            prev_en_q  <= en_q;
            cnt_q      <= cnt_d;
            slot_q     <= slot_d;
            slot_err_q <= slot_err_d;
            mask_q     <= mask_d;
            state_q    <= state_d;
            digits_q   <= digits_d;
            err_q      <= err_d;
            valid_q    <= valid_d;
            overrun_q  <= overrun_d;
        end
    end

    assign frame_o.digits_out = digits_q;
    assign frame_o.err_out    = err_q;
    assign frame_o.out_valid  = valid_q;
    assign frame_o.overrun    = overrun_q;

endmodule

// File: doc/seven_segment_scan_reader.md
# seven_segment_scan_reader

Reads a multiplexed seven-segment display bus (segment lines plus one-hot digit strobes) and recovers the BCD value of every digit. It is the inverse of our BCD-to-seven-segment decoder and sits on the self-check / loopback path: the display outputs of the CPU board are fed back in, and the recovered digits are compared against the register being displayed. Each strobe is debounced, each pattern is decoded back to a nibble with an error flag, and complete frames are presented over a valid/ready handshake.

## Interface

Parameters:
- DIGITS, 4, number of multiplexed digit positions, from 1 to 8.
- STABLE_CYCLES, 4, number of consecutive identical registered samples required before a digit is captured, at least 2.

Ports:
- clk, input, 1, the single clock; all logic is rising-edge.
- rst_n, input, 1, asynchronous active-low reset.
- seg, input, 7, segment lines in bit order a..g = [6:0], active-high.
- digit_en, input, DIGITS, digit strobe; exactly one bit set means that digit is being driven.
- digits_out, output, 4*DIGITS, recovered nibbles; digit i occupies bits [4i+3:4i].
- err_out, output, DIGITS, per-digit decode error flag.
- out_valid, output, 1, a frame is present on digits_out and err_out.
- out_ready, input, 1, the consumer accepts the frame.
- overrun, output, 1, one-cycle pulse when a completed frame is dropped.

## Operation

Input stage:
- seg and digit_en are registered once into seg_q and en_q.
- All further logic uses only the registered copies.

Stability counter:
- The counter increments (saturating at STABLE_CYCLES) while {seg_q, en_q} equals the previous cycle's value and en_q is one-hot.
- Any change, or an en_q that is zero or multi-hot, resets the counter to 0.
- A capture fires exactly once per stable run, in the cycle the counter reaches STABLE_CYCLES-1, which is the STABLE_CYCLES-th identical sample.

Decode on capture (value in hex -> nibble):
- 7E->0, 30->1, 6D->2, 79->3, 33->4, 5B->5, 5F->6, 70->7, 7F->8, 7B->9, all with err=0.
- 4F (the "E" glyph) -> 4'hE, err=1.
- Any other pattern -> 4'hF, err=1.

Capture write:
- The decoded nibble and err bit are written into slot[idx], where idx is the index of the set bit in en_q.
- Mask bit idx is set.
- If the same slot is recaptured within a frame, the latest value wins.

FSM:
- COLLECT, when mask is all ones:
  - Load digits_out and err_out from the slots, including any capture written in that same cycle.
  - Set out_valid, clear mask, go to PRESENT.
- PRESENT:
  - The outputs are held stable.
  - Capture into the slots and mask continues.
  - If out_valid && out_ready: clear out_valid and go to COLLECT. The mask is kept, so a frame already under collection is not lost.
  - If the mask becomes all ones while still in PRESENT with no handshake: pulse overrun, clear mask, discard those slots, stay in PRESENT.
  - If the handshake and a full mask occur in the same cycle: the handshake takes priority, state goes to COLLECT with the mask intact, and the new frame is presented on the next cycle. No overrun.

Reset:
- Asynchronous, active-low.
- Outputs: digits_out=0, err_out=0, out_valid=0, overrun=0.
- Internal: state=COLLECT, mask=0, counter=0, slots=0, seg_q=0, en_q=0.
- A reset in mid-frame discards partial captures.

## Timing

- Pin to registered sample: 1 cycle.
- A pattern held constant on the pins from cycle t is captured at edge t+STABLE_CYCLES.
- A capture that completes the mask gives out_valid=1 at the following edge.
- With DIGITS=4, STABLE_CYCLES=4 and each strobe held 4 cycles, the first frame appears 17 cycles after the first strobe edge.
- out_valid stays high, with stable data, until the cycle after out_valid && out_ready.
- overrun lasts exactly 1 cycle.
- Minimum strobe dwell is STABLE_CYCLES cycles. Shorter dwells are never captured.

## Test plan

- Reset, then scan digits 3,1,4,1 (strobe 0001..1000, seg=79,30,33,30), 6 cycles each, with out_ready=1 -> one out_valid pulse; digits_out=16'h1413; err_out=0.
- Strobe 0010 with seg=30 held for only 3 cycles, then change -> no capture; mask unchanged; out_valid stays 0.
- Scan a frame with seg=4F on digit 2 and seg=00 on digit 0 -> digit2=E and digit0=F; err_out=4'b0101.
- out_ready=0 and two full frames scanned -> first frame held unchanged; overrun pulses once at second completion; after out_ready=1, out_valid drops; next full scan presents the third frame.
- digit_en=0011 or 0000 for 10 cycles -> no capture; counter held at 0.
- rst_n pulled low mid-frame after 2 digits captured -> all outputs 0 immediately; after release, 4 fresh captures are needed before out_valid.
